// File: rtl/sccb_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sccb_config_sequencer                                      |
// | Description : Walks a register/value table and issues one SCCB write per |
// |               entry to an external SCCB master. It waits a settle time   |
// |               after start and an idle gap between writes. An entry of    |
// |               16'hFFFF ends the table early.                             |
// | Option      : define SCCB_RETRY_EN to retry a nacked write up to three   |
// |               times (four attempts) before aborting.                     |
// | Ports       : clk_i        - system clock, rising edge                   |
// |               reset_ni     - asynchronous active-low reset               |
// |               start_i      - single-cycle request to run the table       |
// |               tbl_idx_o    - table read index                            |
// |               tbl_data_i   - entry at tbl_idx_o {addr[15:8], value[7:0]} |
// |               sccb_req_o   - write request to the SCCB master            |
// |               sccb_addr_o  - register address of the current write       |
// |               sccb_data_o  - register value of the current write         |
// |               sccb_ack_i   - master accepted the request (pulse)         |
// |               sccb_done_i  - transaction finished (pulse)                |
// |               sccb_nack_i  - slave did not acknowledge (valid with done) |
// |               busy_o       - sequence running                            |
// |               done_o       - sequence completed OK                       |
// |               error_o      - sequence aborted                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sccb_config_sequencer #(
  parameter  int NUM_REGS      = 8,
  parameter  int SETTLE_CYCLES = 100000,
  parameter  int GAP_CYCLES    = 100,
  localparam int IW            = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          start_i,
  output logic [IW-1:0] tbl_idx_o,
  input  logic [15:0]   tbl_data_i,
  output logic          sccb_req_o,
  output logic [7:0]    sccb_addr_o,
  output logic [7:0]    sccb_data_o,
  input  logic          sccb_ack_i,
  input  logic          sccb_done_i,
  input  logic          sccb_nack_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o
);

  // Shared down-counter for the settle time and the inter-write gap.
  localparam int c_cnt_max   = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int c_cnt_w_raw = $clog2(c_cnt_max + 1);
  localparam int c_cnt_w     = (c_cnt_w_raw < 1) ? 1 : c_cnt_w_raw;

  // A zero-length wait is treated as one cycle: loading 0 still spends the
  // cycle in which the counter is observed to be zero.
  localparam logic [c_cnt_w-1:0] c_settle_load =
      (SETTLE_CYCLES > 1) ? c_cnt_w'(SETTLE_CYCLES - 1) : '0;
  localparam logic [c_cnt_w-1:0] c_gap_load =
      (GAP_CYCLES > 1) ? c_cnt_w'(GAP_CYCLES - 1) : '0;
  localparam logic [IW-1:0]      c_last_idx = IW'(NUM_REGS - 1);
  localparam logic [15:0]        c_end_marker = 16'hFFFF;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_settle = 3'd1;
  localparam logic [2:0] c_st_fetch  = 3'd2;
  localparam logic [2:0] c_st_req    = 3'd3;
  localparam logic [2:0] c_st_wait   = 3'd4;
  localparam logic [2:0] c_st_gap    = 3'd5;
  localparam logic [2:0] c_st_done   = 3'd6;
  localparam logic [2:0] c_st_error  = 3'd7;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [IW-1:0]      r_idx;
  logic [7:0]         r_addr;
  logic [7:0]         r_data;
  logic               r_req;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               w_req_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_error_nxt;
  logic               w_cnt_zero;
  logic               w_last_idx;

`ifdef SCCB_RETRY_EN
  // Number of nacks already seen for the current entry.
  logic [1:0]         r_retry;
`endif

  assign w_cnt_zero = (r_cnt == '0);
  assign w_last_idx = (r_idx == c_last_idx);

  // State register, with the outputs registered alongside it so that they
  // never glitch on next-state decoding.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= c_st_idle;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle, c_st_done, c_st_error: begin
        if (start_i) w_state_nxt = c_st_settle;
      end
      c_st_settle: begin
        if (w_cnt_zero) w_state_nxt = c_st_fetch;
      end
      c_st_fetch: begin
        w_state_nxt = (tbl_data_i == c_end_marker) ? c_st_done : c_st_req;
      end
      c_st_req: begin
        if (sccb_ack_i) w_state_nxt = c_st_wait;
      end
      c_st_wait: begin
        if (sccb_done_i) begin
          if (!sccb_nack_i) begin
            w_state_nxt = c_st_gap;
          end else begin
`ifdef SCCB_RETRY_EN
            w_state_nxt = (r_retry == 2'd3) ? c_st_error : c_st_req;
`else
            w_state_nxt = c_st_error;
`endif
          end
        end
      end
      c_st_gap: begin
        if (w_cnt_zero) w_state_nxt = w_last_idx ? c_st_done : c_st_fetch;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Output decode of the upcoming state; captured by the state register.
  always_comb begin
    w_req_nxt   = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_error_nxt = 1'b0;
    case (w_state_nxt)
      c_st_settle, c_st_fetch, c_st_wait, c_st_gap: w_busy_nxt = 1'b1;
      c_st_req: begin
        w_busy_nxt = 1'b1;
        w_req_nxt  = 1'b1;
      end
      c_st_done:  w_done_nxt  = 1'b1;
      c_st_error: w_error_nxt = 1'b1;
      default: ;
    endcase
  end

  // Counter, table index and write operands.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_addr  <= 8'h00;
      r_data  <= 8'h00;
`ifdef SCCB_RETRY_EN
      r_retry <= 2'd0;
`endif
    end else begin
      case (r_state)
        c_st_idle, c_st_done, c_st_error: begin
          if (start_i) begin
            r_cnt <= c_settle_load;
            r_idx <= '0;
          end
        end
        c_st_settle: begin
          if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
        end
        c_st_fetch: begin
          r_addr  <= tbl_data_i[15:8];
          r_data  <= tbl_data_i[7:0];
`ifdef SCCB_RETRY_EN
          r_retry <= 2'd0;
`endif
        end
        c_st_wait: begin
          if (sccb_done_i) begin
            if (!sccb_nack_i) begin
              r_cnt <= c_gap_load;
            end
`ifdef SCCB_RETRY_EN
            else if (r_retry != 2'd3) begin
              r_retry <= r_retry + 2'd1;
            end
`endif
          end
        end
        c_st_gap: begin
          // The index stops at the last entry so it can never wrap.
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!w_last_idx) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tbl_idx_o   = r_idx;
  assign sccb_req_o  = r_req;
  assign sccb_addr_o = r_addr;
  assign sccb_data_o = r_data;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign error_o     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sccb_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sccb_config_sequencer                                   |
// | Description : Self-checking bench for sccb_config_sequencer. Plays the   |
// |               SCCB master, checks write order, operands, timing and end  |
// |               status against a table-walk reference model.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sccb_config_sequencer;

  localparam int NR     = 3;
  localparam int ST     = 10;
  localparam int GP     = 4;
  localparam int BUDGET = 3000;
`ifdef SCCB_RETRY_EN
  localparam int MAX_ATT = 4;
`else
  localparam int MAX_ATT = 1;
`endif

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  tbl_idx_o;
  logic [15:0] tbl_data_i;
  logic        sccb_req_o;
  logic [7:0]  sccb_addr_o;
  logic [7:0]  sccb_data_o;
  logic        sccb_ack_i = 1'b0;
  logic        sccb_done_i = 1'b0;
  logic        sccb_nack_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  always #5 clk_i = ~clk_i;

  // Entry 3 lies past the table; a wrapped or overrun index shows up as DEAD.
  logic [15:0] tbl_mem [4];
  assign tbl_data_i = tbl_mem[tbl_idx_o];

  sccb_config_sequencer #(
    .NUM_REGS      (NR),
    .SETTLE_CYCLES (ST),
    .GAP_CYCLES    (GP)
  ) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .tbl_idx_o   (tbl_idx_o),
    .tbl_data_i  (tbl_data_i),
    .sccb_req_o  (sccb_req_o),
    .sccb_addr_o (sccb_addr_o),
    .sccb_data_o (sccb_data_o),
    .sccb_ack_i  (sccb_ack_i),
    .sccb_done_i (sccb_done_i),
    .sccb_nack_i (sccb_nack_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] t0;
    logic [15:0] t1;
    logic [15:0] t2;
    int          ack_dly;
    int          done_dly;
    logic [31:0] nack_mask;  // bit k = nack on the k-th attempt of the run
    bit          gap_start;  // pulse start_i while in the first gap
    int          exp_nw;
    bit          exp_err;
  } vec_t;

  // Reference model: expected write list and outcome of one table run.
  logic [15:0] exp_q[$];
  bit          exp_err_m;
  bit          exp_marker;

  task automatic model(input logic [15:0] t0, input logic [15:0] t1,
                       input logic [15:0] t2, input logic [31:0] mask);
    logic [15:0] t [3];
    int att;
    int tries;
    bit ok;
    t[0] = t0; t[1] = t1; t[2] = t2;
    exp_q.delete();
    exp_err_m  = 1'b0;
    exp_marker = 1'b0;
    att = 0;
    for (int i = 0; i < NR; i++) begin
      if (t[i] == 16'hFFFF) begin
        exp_marker = 1'b1;
        break;
      end
      tries = 0;
      ok    = 1'b0;
      while (!ok && !exp_err_m) begin
        exp_q.push_back(t[i]);
        if (mask[att]) begin
          tries++;
          if (tries == MAX_ATT) exp_err_m = 1'b1;
        end else begin
          ok = 1'b1;
        end
        att++;
      end
      if (exp_err_m) break;
    end
  endtask

  // Start the sequence, act as the master, and check everything observed.
  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] got_q[$];
    logic [15:0] cur;
    int cyc, ph, cnt, att, exp_req, next_fetch, err_end, exp_end, poke;
    int stab_bad, busy_bad;
    bit first_ok;
    tbl_mem[0] = v.t0; tbl_mem[1] = v.t1; tbl_mem[2] = v.t2;
    model(v.t0, v.t1, v.t2, v.nack_mask);
    cyc = 0; ph = 0; cnt = 0; att = 0; poke = -1;
    stab_bad = 0; busy_bad = 0; first_ok = 1'b0; cur = 16'h0;
    next_fetch = ST;       // FETCH seen SETTLE cycles after the start edge
    exp_req    = ST + 1;
    err_end    = -1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    while (!(done_o || error_o) && cyc < BUDGET) begin
      sccb_ack_i  = 1'b0;
      sccb_done_i = 1'b0;
      sccb_nack_i = 1'b0;
      start_i     = (cyc == poke);
      if (!busy_o) busy_bad++;
      if (ph == 0 && sccb_req_o) begin
        got_q.push_back({sccb_addr_o, sccb_data_o});
        chk({tag, " req_time"}, cyc, exp_req);
        cur = {sccb_addr_o, sccb_data_o};
        cnt = v.ack_dly;
        ph  = 1;
      end
      if (ph == 1) begin
        if (!sccb_req_o || {sccb_addr_o, sccb_data_o} !== cur) stab_bad++;
        if (cnt == 0) begin
          sccb_ack_i = 1'b1;
          cnt = v.done_dly;
          ph  = 2;
        end else begin
          cnt--;
        end
      end else if (ph == 2) begin
        if (sccb_req_o) stab_bad++;
        if (cnt == 0) begin
          sccb_done_i = 1'b1;
          sccb_nack_i = v.nack_mask[att];
          if (v.nack_mask[att]) begin
            exp_req = cyc + 1;
            err_end = cyc + 1;
          end else begin
            next_fetch = cyc + 1 + GP;
            exp_req    = next_fetch + 1;
            if (!first_ok && v.gap_start) poke = cyc + 2;
            first_ok = 1'b1;
          end
          att++;
          ph = 0;
        end else begin
          cnt--;
        end
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    sccb_ack_i = 1'b0; sccb_done_i = 1'b0; sccb_nack_i = 1'b0; start_i = 1'b0;
    if (exp_err_m)       exp_end = err_end;
    else if (exp_marker) exp_end = next_fetch + 1;
    else                 exp_end = next_fetch;
    chk({tag, " no_timeout"}, (cyc < BUDGET), 1);
    chk({tag, " end_time"}, cyc, exp_end);
    chk({tag, " done_o"}, done_o, !v.exp_err);
    chk({tag, " error_o"}, error_o, v.exp_err);
    chk({tag, " busy_end"}, busy_o, 0);
    chk({tag, " busy_run"}, busy_bad, 0);
    chk({tag, " req_stable"}, stab_bad, 0);
    chk({tag, " nwrites"}, got_q.size(), v.exp_nw);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, " write"}, got_q[i], exp_q[i]);
    // The sequencer must stay quiet in DONE/ERROR.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk({tag, " post_quiet"}, {sccb_req_o, busy_o, done_o, error_o},
          {2'b00, !v.exp_err, v.exp_err});
    end
  endtask

  vec_t vecs [8];

  initial begin
    vec_t rv;
    int n;
    tbl_mem[3] = 16'hDEAD;

    //             t0       t1       t2      ack dn  mask gap nw err
    vecs[0] = '{16'h1280, 16'h1101, 16'h3A04, 1, 4, 32'h0, 0, 3, 0};
    vecs[1] = '{16'h1280, 16'hFFFF, 16'h3A04, 1, 4, 32'h0, 0, 1, 0};
    vecs[2] = '{16'h1280, 16'hFFFF, 16'h3A04, 50, 2, 32'h0, 0, 1, 0};
`ifdef SCCB_RETRY_EN
    vecs[3] = '{16'h1280, 16'h1101, 16'h3A04, 1, 4, 32'hF, 0, 4, 1};
    vecs[4] = '{16'h1280, 16'h1101, 16'h3A04, 1, 4, 32'h1, 0, 4, 0};
`else
    vecs[3] = '{16'h1280, 16'h1101, 16'h3A04, 1, 4, 32'hF, 0, 1, 1};
    vecs[4] = '{16'h1280, 16'h1101, 16'h3A04, 1, 4, 32'h1, 0, 1, 1};
`endif
    vecs[5] = '{16'hFFFF, 16'h1101, 16'h3A04, 0, 0, 32'h0, 0, 0, 0};
    vecs[6] = '{16'h1280, 16'h1101, 16'h3A04, 2, 3, 32'h0, 1, 3, 0};
    vecs[7] = '{16'h5566, 16'h7788, 16'hFFFF, 0, 0, 32'h0, 0, 2, 0};

    // Reset values.
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outs", {busy_o, done_o, error_o, sccb_req_o, sccb_addr_o,
                       sccb_data_o, tbl_idx_o}, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(posedge clk_i); #1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset while waiting for the master's done.
    tbl_mem[0] = 16'h1280; tbl_mem[1] = 16'h1101; tbl_mem[2] = 16'h3A04;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0;
    while (!sccb_req_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("rst_reach_req", sccb_req_o, 1);
    chk("rst_pre_addr", sccb_addr_o, 8'h12);
    sccb_ack_i = 1'b1;
    @(posedge clk_i); #1;
    sccb_ack_i = 1'b0;
    @(posedge clk_i); #2;
    chk("rst_in_wait_busy", busy_o, 1);
    reset_ni = 1'b0;
    #1;
    chk("rst_async_outs", {busy_o, done_o, error_o, sccb_req_o, sccb_addr_o,
                           sccb_data_o, tbl_idx_o}, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    // A stray done pulse in IDLE must be ignored.
    sccb_done_i = 1'b1;
    @(posedge clk_i); #1;
    sccb_done_i = 1'b0;
    @(posedge clk_i); #1;
    chk("idle_after_rst", {busy_o, done_o, error_o, sccb_req_o}, 0);

    // Randomized tables, master latencies and nack patterns.
    for (int r = 0; r < 20; r++) begin
      rv.t0 = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      rv.t1 = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      rv.t2 = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      rv.ack_dly  = $urandom_range(0, 6);
      rv.done_dly = $urandom_range(0, 6);
      rv.nack_mask = 32'h0;
      for (int b = 0; b < 14; b++)
        rv.nack_mask[b] = ($urandom_range(0, 4) == 0);
      rv.gap_start = $urandom_range(0, 1);
      model(rv.t0, rv.t1, rv.t2, rv.nack_mask);
      rv.exp_nw  = exp_q.size();
      rv.exp_err = exp_err_m;
      run_vec(rv, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
